// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus receive monitor: FSM states,
// HD44780 command opcodes and DDRAM address wrap points.
package lcd_pkg;

    typedef enum logic [1:0] {
        INIT8   = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h20;

    localparam logic [6:0] ADDR_LINE1_END   = 7'h27;
    localparam logic [6:0] ADDR_LINE2_START = 7'h40;
    localparam logic [6:0] ADDR_LINE2_END   = 7'h67;

    // Post-write cursor advance; only the two line ends wrap, anything else is +1 mod 128
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (a == ADDR_LINE1_END)      return ADDR_LINE2_START;
        else if (a == ADDR_LINE2_END) return 7'h00;
        else                          return a + 7'd1;
    endfunction

endpackage

// File: rtl/lcd_sync.sv
// Two-flop synchronizer for a bundle of asynchronous inputs.
module lcd_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lcd_rx_monitor.sv
// Snoops a 4-bit HD44780 bus, reassembles bytes and tracks the DDRAM address.
// Optional E high-width check enabled by defining LCD_RX_TIMING_CHECK_EN.
module lcd_rx_monitor
    import lcd_pkg::*;
#(
    parameter int unsigned E_MIN_HIGH  = 12,
    parameter int unsigned NIB_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lcd_d,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       byte_valid,
    output logic [6:0] char_addr,
    output logic       mode_4bit,
    output logic       desync_err,
    output logic       timing_err
);

    localparam int unsigned TMO_W = $clog2(NIB_TIMEOUT + 1);

    localparam logic [1:0] S_INIT8   = 2'(INIT8);
    localparam logic [1:0] S_WAIT_HI = 2'(WAIT_HI);
    localparam logic [1:0] S_WAIT_LO = 2'(WAIT_LO);

    logic [6:0] sync_q;
    logic [3:0] d_d;
    logic       e_d, rs_d, rw_d;
    logic       e_s;
    logic       e_fall, strobe;
    logic [7:0] assembled;

    logic [1:0]       state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic             hi_rs_q, hi_rs_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       byte_out_d;
    logic             byte_rs_d, byte_valid_d, mode_d, desync_d;
    logic [6:0]       char_addr_d;

    lcd_sync #(.WIDTH(7)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({lcd_rw, lcd_rs, lcd_e, lcd_d}),
        .q     (sync_q)
    );

    assign e_s = sync_q[4];

    // One-cycle-old copy: edge detect and the bus values captured with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_d  <= '0;
            e_d  <= 1'b0;
            rs_d <= 1'b0;
            rw_d <= 1'b0;
        end else begin
            d_d  <= sync_q[3:0];
            e_d  <= e_s;
            rs_d <= sync_q[5];
            rw_d <= sync_q[6];
        end
    end

    assign e_fall    = e_d & ~e_s;
    assign strobe    = e_fall & ~rw_d;
    assign assembled = {hi_q, d_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT8;
            hi_q       <= '0;
            hi_rs_q    <= 1'b0;
            tmo_q      <= '0;
            addr_q     <= '0;
            byte_out   <= '0;
            byte_rs    <= 1'b0;
            byte_valid <= 1'b0;
            char_addr  <= '0;
            mode_4bit  <= 1'b0;
            desync_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            hi_rs_q    <= hi_rs_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            byte_out   <= byte_out_d;
            byte_rs    <= byte_rs_d;
            byte_valid <= byte_valid_d;
            char_addr  <= char_addr_d;
            mode_4bit  <= mode_d;
            desync_err <= desync_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        hi_rs_d      = hi_rs_q;
        tmo_d        = tmo_q;
        addr_d       = addr_q;
        byte_out_d   = byte_out;
        byte_rs_d    = byte_rs;
        byte_valid_d = 1'b0;
        char_addr_d  = char_addr;
        mode_d       = mode_4bit;
        desync_d     = 1'b0;

        case (state_q)
            S_INIT8: begin
                if (strobe && !rs_d && d_d == 4'h2) begin
                    state_d = S_WAIT_HI;
                    mode_d  = 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (strobe) begin
                    hi_d    = d_d;
                    hi_rs_d = rs_d;
                    tmo_d   = '0;
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (strobe && rs_d == hi_rs_q) begin
                    byte_out_d   = assembled;
                    byte_rs_d    = rs_d;
                    byte_valid_d = 1'b1;
                    state_d      = S_WAIT_HI;
                    if (rs_d) begin
                        char_addr_d = addr_q;
                        addr_d      = next_addr(addr_q);
                    end else if ((assembled & CMD_SET_DDRAM) != 8'h00) begin
                        addr_d = assembled[6:0];
                    end else if (assembled == CMD_CLEAR || assembled[7:1] == CMD_HOME[7:1]) begin
                        addr_d = '0;
                    end else if (assembled[7:5] == CMD_FUNC_SET[7:5] && assembled[4]) begin
                        // 8-bit function set: host is re-initialising the panel
                        state_d = S_INIT8;
                        mode_d  = 1'b0;
                    end
                end else if (strobe) begin
                    // RS flipped mid-byte: treat this nibble as a fresh upper half
                    desync_d = 1'b1;
                    hi_d     = d_d;
                    hi_rs_d  = rs_d;
                    tmo_d    = '0;
                end else if (tmo_q == TMO_W'(NIB_TIMEOUT)) begin
                    desync_d = 1'b1;
                    state_d  = S_WAIT_HI;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_INIT8;
        endcase
    end

`ifdef LCD_RX_TIMING_CHECK_EN
    localparam int unsigned EW_W = $clog2(E_MIN_HIGH + 1);

    logic [EW_W-1:0] e_cnt;

    // Saturating count of synchronized E high cycles, sampled at the falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_cnt      <= '0;
            timing_err <= 1'b0;
        end else begin
            if (!e_s)                             e_cnt <= '0;
            else if (e_cnt != EW_W'(E_MIN_HIGH))  e_cnt <= e_cnt + EW_W'(1);
            timing_err <= strobe && (e_cnt < EW_W'(E_MIN_HIGH));
        end
    end
`else
    assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Scoreboard bench for lcd_rx_monitor: directed bus sequences plus random
// nibble traffic checked against a behavioural model of the LCD protocol.
module tb_lcd_rx_monitor;

    localparam int NT    = 100;
    localparam int E_MIN = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] lcd_d = 4'h0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] byte_out;
    logic       byte_rs, byte_valid, mode_4bit, desync_err, timing_err;
    logic [6:0] char_addr;

    lcd_rx_monitor #(.E_MIN_HIGH(E_MIN), .NIB_TIMEOUT(NT)) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_d      (lcd_d),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .byte_out   (byte_out),
        .byte_rs    (byte_rs),
        .byte_valid (byte_valid),
        .char_addr  (char_addr),
        .mode_4bit  (mode_4bit),
        .desync_err (desync_err),
        .timing_err (timing_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;      // negative: arrival time not pinned
        bit       valid;
        bit       desync;
        bit       terr;
        bit [7:0] b;
        bit       rs;
        bit [6:0] addr;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model: protocol-level view of the bus
    bit       m_mode = 0;
    bit       m_has_hi = 0;
    bit [3:0] m_hi;
    bit       m_hi_rs;
    bit [6:0] m_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input bit v, input bit de, input bit te,
                           input bit [7:0] b, input bit rs, input bit [6:0] a);
        ev_t e;
        e.cyc = c; e.valid = v; e.desync = de; e.terr = te; e.b = b; e.rs = rs; e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic model_strobe(input bit [3:0] nib, input bit rs, input bit rw,
                                input int eh, input int c);
        bit       te;
        bit [7:0] b;
        int       bv;
        if (rw) return;
`ifdef LCD_RX_TIMING_CHECK_EN
        te = (eh < E_MIN);
`else
        te = 0;
`endif
        if (!m_mode) begin
            if (!rs && nib == 4'h2) begin
                m_mode = 1;
                m_has_hi = 0;
            end
            if (te) push_ev(c, 0, 0, 1, 0, 0, 0);
        end else if (!m_has_hi) begin
            m_has_hi = 1; m_hi = nib; m_hi_rs = rs;
            if (te) push_ev(c, 0, 0, 1, 0, 0, 0);
        end else if (rs != m_hi_rs) begin
            m_hi = nib; m_hi_rs = rs;
            push_ev(c, 0, 1, te, 0, 0, 0);
        end else begin
            b  = {m_hi, nib};
            bv = int'(b);
            m_has_hi = 0;
            push_ev(c, 1, 0, te, b, rs, m_addr);
            if (rs) begin
                if (m_addr == 7'h27)      m_addr = 7'h40;
                else if (m_addr == 7'h67) m_addr = 7'h00;
                else                      m_addr = 7'((int'(m_addr) + 1) % 128);
            end else if (bv >= 1 && bv <= 3) begin
                m_addr = 0;
            end else if (bv >= 128) begin
                m_addr = 7'(bv - 128);
            end else if (bv >= 'h30 && bv <= 'h3F) begin
                m_mode = 0;
            end
        end
    endtask

    task automatic send(input bit [3:0] nib, input bit rs, input bit rw, input int eh, input int el);
        @(negedge clk);
        lcd_d = nib; lcd_rs = rs; lcd_rw = rw; lcd_e = 1'b1;
        repeat (eh) @(negedge clk);
        lcd_e = 1'b0;
        model_strobe(nib, rs, rw, eh, cyc + 3);
        repeat (el) @(negedge clk);
        check("mode_4bit", 32'(mode_4bit), 32'(m_mode));
    endtask

    task automatic send_byte(input bit [7:0] b, input bit rs, input int eh);
        send(b[7:4], rs, 0, eh, 6);
        send(b[3:0], rs, 0, eh, 6);
    endtask

    task automatic idle(input int n);
        if (n > NT + 10 && m_mode && m_has_hi) begin
            push_ev(-1, 0, 1, 0, 0, 0, 0);
            m_has_hi = 0;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_byte_out",   32'(byte_out),   0);
        check("rst_byte_rs",    32'(byte_rs),    0);
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_char_addr",  32'(char_addr),  0);
        check("rst_mode_4bit",  32'(mode_4bit),  0);
        check("rst_desync",     32'(desync_err), 0);
        check("rst_timing",     32'(timing_err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check("queue_drained_before_reset", 32'(exp_q.size()), 0);
        reset = 1'b1; lcd_e = 1'b0;
        m_mode = 0; m_has_hi = 0; m_addr = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
    endtask

    // Monitor: every output pulse must match the next expected event
    ev_t mon_e;
    bit  mon_ok;
    always @(negedge clk) begin
        if (!reset && (byte_valid || desync_err || timing_err)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got valid=%0b desync=%0b terr=%0b byte=%0h at cycle %0d, required none",
                         byte_valid, desync_err, timing_err, byte_out, cyc);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ok = (byte_valid == mon_e.valid) && (desync_err == mon_e.desync) &&
                         (timing_err == mon_e.terr) && (mon_e.cyc < 0 || mon_e.cyc == cyc) &&
                         (!mon_e.valid || (byte_out == mon_e.b && byte_rs == mon_e.rs &&
                                           (!mon_e.rs || char_addr == mon_e.addr)));
                if (!mon_ok) begin
                    n_bad++;
                    $display("FAIL event: got valid=%0b desync=%0b terr=%0b byte=%0h rs=%0b addr=%0h cyc=%0d, required valid=%0b desync=%0b terr=%0b byte=%0h rs=%0b addr=%0h cyc=%0d",
                             byte_valid, desync_err, timing_err, byte_out, byte_rs, char_addr, cyc,
                             mon_e.valid, mon_e.desync, mon_e.terr, mon_e.b, mon_e.rs, mon_e.addr, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit rs;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Initialisation nibbles; only the final 0x2 enters 4-bit mode
        send(4'h3, 0, 0, 12, 6);
        send(4'h3, 0, 0, 12, 6);
        send(4'h3, 0, 0, 12, 6);
        send(4'h2, 0, 0, 12, 6);

        send_byte(8'h80, 0, 12);
        send_byte(8'h41, 1, 12);
        send_byte(8'h42, 1, 12);

        send_byte(8'hA7, 0, 12);
        send_byte(8'h61, 1, 14);
        send_byte(8'h62, 1, 12);
        send_byte(8'hE7, 0, 12);
        send_byte(8'h63, 1, 12);
        send_byte(8'h64, 1, 12);
        send_byte(8'hFF, 0, 12);
        send_byte(8'h65, 1, 12);
        send_byte(8'h66, 1, 12);
        send_byte(8'h01, 0, 12);
        send_byte(8'h67, 1, 12);

        // Lone upper nibble times out, then a clean byte
        send(4'h4, 1, 0, 12, 6);
        idle(NT + 40);
        send_byte(8'h31, 1, 12);

        // RS mismatch restarts the byte on the second nibble
        send(4'h5, 1, 0, 12, 6);
        send(4'h6, 0, 0, 12, 6);
        send(4'h7, 0, 0, 12, 6);

        // Read strobes are invisible
        send(4'h9, 1, 1, 12, 6);
        send_byte(8'h48, 1, 12);

        // Short E pulse still assembles
        send_byte(8'h52, 1, 5);

        // 8-bit function set drops back to init; data there is discarded
        send_byte(8'h30, 0, 12);
        send(4'h5, 1, 0, 12, 6);
        send(4'h2, 1, 0, 12, 6);
        send(4'h2, 0, 0, 12, 6);
        send_byte(8'h28, 0, 12);
        send_byte(8'h02, 0, 12);
        send_byte(8'h49, 1, 12);

        // Reset between nibbles drops the partial byte
        send(4'h4, 1, 0, 12, 6);
        do_reset();
        send(4'h1, 1, 0, 12, 6);
        send(4'h2, 0, 0, 12, 6);
        send_byte(8'h50, 1, 12);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                idle(NT + 30);
            end else if (r < 12 && !m_has_hi) begin
                send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1,
                     $urandom_range(2, 20), $urandom_range(4, 10));
            end else if (r < 16) begin
                idle($urandom_range(2, 20));
            end else if (!m_mode && $urandom_range(0, 1) == 1) begin
                send(4'h2, 0, 0, $urandom_range(2, 20), $urandom_range(4, 10));
            end else begin
                if (m_has_hi) rs = ($urandom_range(0, 99) < 85) ? m_hi_rs : ~m_hi_rs;
                else          rs = 1'($urandom_range(0, 1));
                send(4'($urandom_range(0, 15)), rs, 0,
                     $urandom_range(2, 20), $urandom_range(4, 10));
            end
        end

        repeat (20) @(negedge clk);
        check("queue_empty_at_end", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
